rr_logging_bus_serializer: RTL
==============================

# rr_logging_bus_serializer

Consumes the grouped logging bus produced by the logging-bus grouping tree (`rr_logging_bus_t`, consumer side) and converts each logged transaction record into a stream of fixed-width beats for the log buffer/DMA writer. Each record carries the begin-valid bitmap, the end-valid bitmap and the full packed begin data. The block sits directly downstream of the root grouping stage and upstream of the log FIFO.

## Interface

Parameters:

- `OUT_WIDTH`, 512: output beat width in bits.
- `LOGB_CHANNEL_CNT`, `LOGE_CHANNEL_CNT`, `FULL_WIDTH`: localparams taken from `in`; they are not overridable.
- `HDR_WIDTH`, derived: `LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT`.
- `REC_WIDTH`, derived: `HDR_WIDTH + FULL_WIDTH`.
- `NBEATS`, derived: `ceil(REC_WIDTH / OUT_WIDTH)`, which must be ≥1.
- `BEAT_BITS`, derived: `max(1, clog2(NBEATS))`.

Ports:

- `clk` input 1: the only clock.
- `rst` input 1: synchronous, active-high reset.
- `in` `rr_logging_bus_t.C`: carries `logb_valid[LOGB_CHANNEL_CNT]`, `loge_valid[LOGE_CHANNEL_CNT]`, `logb_data[FULL_WIDTH]` and the scalar `ready`, which the block drives.
- `out_valid` output 1: a beat is present.
- `out_data` output OUT_WIDTH: beat payload.
- `out_last` output 1: marks the final beat of a record.
- `out_ready` input 1: downstream accepts the beat.
- `record_cnt` output 64: count of fully emitted records.

## Operation

Record layout, LSB first:
- `[LOGB_CHANNEL_CNT-1:0]` = `logb_valid`.
- Next `LOGE_CHANNEL_CNT` bits = `loge_valid`.
- Next `FULL_WIDTH` bits = `logb_data`.
- Zero-pad up to `NBEATS*OUT_WIDTH`.
- Beat k = bits `[k*OUT_WIDTH +: OUT_WIDTH]`.
- Data bits belonging to channels whose `logb_valid` is low are passed through unmodified, not masked.

State machine `IDLE`/`SEND`, with a beat counter `beat`:
- **IDLE:**
  - `in.ready`=1.
  - Capture condition: `|logb_valid || |loge_valid`.
  - When the capture condition holds, latch the full record into `rec_q`, set `beat`=0 and go to SEND.
  - Otherwise stay in IDLE; nothing is latched.
- **SEND:**
  - `in.ready`=0.
  - `out_valid`=1, `out_data`=beat `beat` of `rec_q`, `out_last`=(`beat==NBEATS-1`).
  - On `out_valid && out_ready`:
    - If `out_last`: go to IDLE and increment `record_cnt`.
    - Otherwise: `beat++`.
  - Without `out_ready`, all outputs hold stable (AXI-stream rules). `out_valid` never drops before the handshake.
- `NBEATS==1`: every beat is the last beat, and `beat` stays 0.
- `record_cnt` wraps modulo 2^64 without a flag.
- Upstream stalls for exactly the SEND period. Per-channel valids upstream of the grouping tree rely on a broadcast `ready`, so no per-channel buffering exists here.

## Timing

- Reset values: state=IDLE, `in.ready`=0 while `rst`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `beat`=0, `record_cnt`=0, `rec_q`=0.
- `in.ready` becomes 1 on the first cycle with `rst`=0.
- All outputs are registered or decoded from registered state. There is no combinational path from `in` to `out_*` or from `out_ready` to `in.ready`.
- Latency: first beat valid 1 cycle after the capture handshake.
- Throughput: one record per `NBEATS+1` cycles when `out_ready` is held high.
- A capture and a last-beat handshake never coincide, because `ready`=0 in SEND. The next capture is possible the cycle after the return to IDLE.
- Reset asserted mid-record drops the partial record: no `out_last` is emitted, `record_cnt` is cleared, and state returns to IDLE the next cycle.
- An input with no valid bit set while `in.ready`=1 is ignored: no beat is emitted and the counter is unchanged.

## Structure

- Shared package `rr_pkg`, alongside `RR_CHANNEL_WIDTH_BITS`, holds:
  - the state enum `rr_ser_state_t`;
  - a `RR_CEIL_DIV` function/macro for the `NBEATS` derivation.
- Elaboration checks live in a generate block using `$error`:
  - `OUT_WIDTH`>0;
  - `REC_WIDTH`>0.
- No sub-module is required. The beat select is an indexed part-select of `rec_q`.

## Test plan

Default test configuration: LOGB=2, LOGE=2, FULL_WIDTH=600, OUT_WIDTH=512, giving REC_WIDTH=604 and NBEATS=2.

1. Reset behaviour:
   - Stimulus: hold `rst` for 3 cycles.
   - Required: all outputs 0 and `in.ready`=0 during reset; `in.ready`=1 on the first cycle after.
2. Single record, back-to-back accept:
   - Stimulus: `logb_valid`=2'b01, `loge_valid`=2'b10, data=600'hABC; `out_ready`=1.
   - Required beat 0: bits[3:0]=4'b1001, bits[15:4]=12'hABC.
   - Required beat 1: `out_last`=1, upper bits zero-padded.
   - Required counters: `record_cnt`=1; `in.ready` returns to 1 two cycles after capture.
3. Backpressure:
   - Stimulus: hold `out_ready`=0 for 5 cycles during beat 0.
   - Required: `out_data`/`out_last` stable throughout; `in.ready`=0 throughout; resuming completes both beats.
4. Idle input:
   - Stimulus: all valids 0 for 10 cycles.
   - Required: `out_valid` stays 0; `record_cnt` unchanged.
5. Reset mid-record:
   - Stimulus: assert `rst` after beat 0 handshake.
   - Required: no `out_last` is emitted; `record_cnt`=0; a new record afterwards serializes correctly.
6. OUT_WIDTH=1024 (NBEATS=1):
   - Stimulus: send three consecutive records.
   - Required: each record is a single beat with `out_last`=1; `record_cnt`=3 after the 6th cycle.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared types and helpers for the logging-bus
// serializer and its bus interface.
package rr_pkg;

  localparam int RR_CHANNEL_WIDTH_BITS = 32;

  typedef enum logic {
    RR_SER_IDLE,
    RR_SER_SEND
  } rr_ser_state_t;

  function automatic int RR_CEIL_DIV(
    input int a,
    input int b
  );
    return (b > 0) ? (a + b - 1) / b : 1;
  endfunction

endpackage

// File: rtl/rr_logging_bus_if.sv
// Grouped logging bus: per-channel begin/end
// valids, packed begin data, broadcast ready.
interface rr_logging_bus_t #(
  parameter int LOGB_CHANNEL_CNT = 2,
  parameter int LOGE_CHANNEL_CNT = 2,
  parameter int FULL_WIDTH =
    LOGB_CHANNEL_CNT * rr_pkg::RR_CHANNEL_WIDTH_BITS
) ();

  logic [LOGB_CHANNEL_CNT-1:0] logb_valid;
  logic [LOGE_CHANNEL_CNT-1:0] loge_valid;
  logic [FULL_WIDTH-1:0]       logb_data;
  logic                        ready;

  modport P (
    output logb_valid,
    output loge_valid,
    output logb_data,
    input  ready
  );

  modport C (
    input  logb_valid,
    input  loge_valid,
    input  logb_data,
    output ready
  );

endinterface

// File: rtl/rr_logging_bus_serializer.sv
// Latches one logging record and streams it out
// as fixed-width beats, stalling upstream meanwhile.
module rr_logging_bus_serializer
  import rr_pkg::*;
#(
  parameter int OUT_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_logging_bus_t.C           in,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [63:0]          record_cnt
);

  localparam int LOGB_CHANNEL_CNT = in.LOGB_CHANNEL_CNT;
  localparam int LOGE_CHANNEL_CNT = in.LOGE_CHANNEL_CNT;
  localparam int FULL_WIDTH       = in.FULL_WIDTH;

  localparam int HDR_WIDTH =
    LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
  localparam int REC_WIDTH = HDR_WIDTH + FULL_WIDTH;
  localparam int NBEATS =
    RR_CEIL_DIV(REC_WIDTH, OUT_WIDTH);
  localparam int BEAT_BITS =
    (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int BUF_WIDTH = NBEATS * OUT_WIDTH;

  if (OUT_WIDTH <= 0) begin : g_chk_out_width
    $error("OUT_WIDTH must be positive");
  end
  if (REC_WIDTH <= 0) begin : g_chk_rec_width
    $error("REC_WIDTH must be positive");
  end

  rr_ser_state_t          state_q, state_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [BUF_WIDTH-1:0]   rec_q, rec_d;
  logic [63:0]            cnt_q, cnt_d;
  logic [BUF_WIDTH-1:0]   rec_w;
  logic                   last_w;

  assign out_valid  = (state_q == RR_SER_SEND);
  assign last_w     = out_valid &&
    (beat_q == BEAT_BITS'(NBEATS - 1));
  assign out_last   = last_w;
  assign out_data   = out_valid ?
    rec_q[int'(beat_q) * OUT_WIDTH +: OUT_WIDTH] :
    '0;
  assign record_cnt = cnt_q;
  assign in.ready   = (state_q == RR_SER_IDLE) && !rst;

  // Next-state: capture in IDLE, step beats in SEND
  always_comb begin
    rec_w = '0;
    rec_w[REC_WIDTH-1:0] =
      {in.logb_data, in.loge_valid, in.logb_valid};
    state_d = state_q;
    beat_d  = beat_q;
    rec_d   = rec_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RR_SER_IDLE: begin
        if (|in.logb_valid || |in.loge_valid) begin
          rec_d   = rec_w;
          beat_d  = '0;
          state_d = RR_SER_SEND;
        end
      end
      RR_SER_SEND: begin
        if (out_ready) begin
          if (last_w) begin
            state_d = RR_SER_IDLE;
            cnt_d   = cnt_q + 64'd1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = RR_SER_IDLE;
    endcase
  end

  // State, beat, record and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RR_SER_IDLE;
      beat_q  <= '0;
      rec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rec_q   <= rec_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
